// File: rtl/rf_write_arbiter_pkg.sv
// Shared defaults for the register-file write-back arbiter.
// Optional combinational bypass is enabled by defining RF_ARB_BYPASS_EN.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef REG_ADDR_LEN
`define REG_ADDR_LEN 5
`endif
`ifndef REG_NUM
`define REG_NUM 32
`endif
`ifndef RF_ARB_NUM_REQ
`define RF_ARB_NUM_REQ 3
`endif

package rf_write_arbiter_pkg;

  localparam int RF_ARB_NUM_REQ_DEF = `RF_ARB_NUM_REQ;
  localparam int RF_ARB_DATA_W_DEF  = `DATA_LEN;
  localparam int RF_ARB_ADDR_W_DEF  = `REG_ADDR_LEN;
  localparam int RF_ARB_NREG_DEF    = `REG_NUM;

  function automatic int rr_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from last grant + 1, one-hot grant.
// Part of rf_write_arbiter (optional feature macro RF_ARB_BYPASS_EN unused here).
module rr_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = rr_ptr_w(N);

  logic [PW-1:0] last_q;
  logic [PW-1:0] last_d;
  logic          found;
  int            j;

  always_comb begin
    gnt    = '0;
    found  = 1'b0;
    last_d = last_q;
    j      = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_q) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        last_d = PW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port among NUM_REQ write-back sources.
// Define RF_ARB_BYPASS_EN to add commit-stage bypass read ports.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = RF_ARB_NUM_REQ_DEF,
  parameter int DATA_W  = RF_ARB_DATA_W_DEF,
  parameter int ADDR_W  = RF_ARB_ADDR_W_DEF,
  parameter int NREG    = RF_ARB_NREG_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
`ifdef RF_ARB_BYPASS_EN
  input  logic [ADDR_W-1:0]         byp_raddr1,
  input  logic [ADDR_W-1:0]         byp_raddr2,
  output logic                      byp_hit1,
  output logic                      byp_hit2,
  output logic [DATA_W-1:0]         byp_data1,
  output logic [DATA_W-1:0]         byp_data2,
`endif
  output logic [NREG-1:0]           busy
);

  logic [NUM_REQ-1:0] gnt;
  logic               hs;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;

  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [NREG-1:0]    busy_q, busy_d;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_addr = win_addr | req_addr[i*ADDR_W +: ADDR_W];
        win_data = win_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // x0 requests still consume a grant but never raise the write enable
  always_comb begin
    we_d    = hs && (win_addr != '0);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (hs) begin
      waddr_d = win_addr;
      wdata_d = win_data;
    end
  end

  // reserve after clear so a same-cycle reservation keeps the bit set
  always_comb begin
    busy_d = busy_q;
    if (hs) begin
      busy_d[win_addr] = 1'b0;
    end
    if (rsv_valid) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign busy     = busy_q;

`ifdef RF_ARB_BYPASS_EN
  assign byp_hit1  = we_q && (waddr_q == byp_raddr1) && (byp_raddr1 != '0);
  assign byp_hit2  = we_q && (waddr_q == byp_raddr2) && (byp_raddr2 != '0);
  assign byp_data1 = wdata_q;
  assign byp_data2 = wdata_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios then randomized traffic
// checked against a round-robin / scoreboard reference model.
module tb_rf_write_arbiter;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RN = 32;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             rsv_valid;
  logic [AW-1:0]    rsv_addr;
  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [DW-1:0]    rf_wdata;
  logic [RN-1:0]    busy;

  int total = 0;
  int bad   = 0;

  int            m_last;
  logic [RN-1:0] m_busy;
  logic          m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;

  rf_write_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .NREG(RN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = NR - 1;
    m_busy = '0;
    m_we   = 1'b0;
    m_wa   = '0;
    m_wd   = '0;
  endtask

  function automatic logic [NR-1:0] exp_gnt();
    for (int k = 1; k <= NR; k++) begin
      int j;
      j = (m_last + k) % NR;
      if (req_valid[j]) return NR'(1 << j);
    end
    return '0;
  endfunction

  task automatic set_req(input int i, input logic v,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // one clock: check grant before the edge, commit/scoreboard after it
  task automatic cycle(output logic [NR-1:0] g);
    int            gi;
    logic [AW-1:0] a;
    logic [RN-1:0] nb;
    #1;
    g = exp_gnt();
    chk("ready", 64'(req_ready), 64'(g));
    @(posedge clk);
    #1;
    gi = -1;
    for (int i = 0; i < NR; i++) if (g[i]) gi = i;
    nb = m_busy;
    m_we = 1'b0;
    if (gi >= 0) begin
      m_last = gi;
      a = req_addr[gi*AW +: AW];
      if (a != 0) begin
        m_we = 1'b1;
        m_wa = a;
        m_wd = req_data[gi*DW +: DW];
      end
      nb[a] = 1'b0;
    end
    if (rsv_valid && rsv_addr != 0) nb[rsv_addr] = 1'b1;
    m_busy = nb;
    chk("rf_we", 64'(rf_we), 64'(m_we));
    if (m_we) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(m_wa));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_wd));
    end
    chk("busy", 64'(busy), 64'(m_busy));
  endtask

  logic [NR-1:0] g;
  logic [AW-1:0] plan_wa [4];

  initial begin
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    rst       = 1'b1;
    model_reset();
    #12;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_wa", 64'(rf_waddr), 64'd0);
    chk("rst_wd", 64'(rf_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // all three valid: order 0,1,2,0
    plan_wa[0] = 5'd1; plan_wa[1] = 5'd2;
    plan_wa[2] = 5'd3; plan_wa[3] = 5'd1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'h100 + i));
    for (int n = 0; n < 4; n++) begin
      cycle(g);
      chk("rr_order", 64'(g), 64'(1 << (n % NR)));
      chk("rr_waddr", 64'(rf_waddr), 64'(plan_wa[n]));
    end
    req_valid = '0;

    // single requester
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle(g);
    chk("single_gnt", 64'(g), 64'b010);
    chk("single_wd", 64'(rf_wdata), 64'hDEADBEEF);
    req_valid = '0;
    cycle(g);
    chk("single_idle_we", 64'(rf_we), 64'd0);

    // x0 write
    set_req(0, 1'b1, 5'd0, 32'h1234);
    cycle(g);
    chk("x0_gnt", 64'(g), 64'b001);
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_busy0", 64'(busy[0]), 64'd0);
    req_valid = '0;

    // scoreboard
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    cycle(g);
    chk("sb_set", 64'(busy[7]), 64'd1);
    rsv_valid = 1'b0;
    set_req(2, 1'b1, 5'd7, 32'h77);
    cycle(g);
    chk("sb_clr", 64'(busy[7]), 64'd0);
    req_valid = '0;
    rsv_valid = 1'b1;
    cycle(g);
    set_req(2, 1'b1, 5'd7, 32'h78);
    cycle(g);
    chk("sb_both", 64'(busy[7]), 64'd1);
    req_valid = '0;
    rsv_valid = 1'b0;

    // async reset while a write is in flight
    set_req(1, 1'b1, 5'd5, 32'h55);
    cycle(g);
    chk("pre_rst_we", 64'(rf_we), 64'd1);
    chk("pre_rst_busy", 64'(busy), 64'h80);
    req_valid = '0;
    #2 rst = 1'b1;
    #1;
    chk("arst_we", 64'(rf_we), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 10), DW'(i));
    cycle(g);
    chk("post_rst_gnt", 64'(g), 64'b001);
    req_valid = '0;

    // randomized traffic; requesters hold until granted
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          set_req(i, 1'b1,
                  ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom),
                  DW'($urandom));
        end
      end
      rsv_valid = ($urandom_range(0, 2) == 0);
      rsv_addr  = AW'($urandom);
      cycle(g);
      req_valid = req_valid & ~g;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
